// File: rtl/idma_wdata_burst_ctrl_pkg.sv
// idma_wdata_burst_ctrl_pkg: shared state encoding and default widths for the W-data burst controller.
package idma_wdata_burst_ctrl_pkg;
    localparam int DEF_FIFO_WIDTH = 288;
    localparam int DEF_DATA_W     = 256;
    localparam int DEF_LEN_W      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;
endpackage

// File: rtl/idma_wdata_skid2.sv
// idma_wdata_skid2: 2-entry FIFO-ordered output buffer; each entry carries a last-beat tag.
module idma_wdata_skid2
    import idma_wdata_burst_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             push_last,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_last,
    output logic             valid,
    output logic [1:0]       occ
);
    logic [WIDTH-1:0] data0, data1;
    logic             last0, last1;
    logic [1:0]       wr_idx;

    // a push lands behind whatever survives this cycle's pop
    assign wr_idx = occ - {1'b0, pop};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ   <= '0;
            data0 <= '0;
            data1 <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else if (clr) begin
            occ   <= '0;
            last0 <= 1'b0;
            last1 <= 1'b0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                data0 <= data1;
                last0 <= last1;
            end
            if (push && wr_idx == 2'd0) begin
                data0 <= push_data;
                last0 <= push_last;
            end
            if (push && wr_idx == 2'd1) begin
                data1 <= push_data;
                last1 <= push_last;
            end
        end
    end

    assign valid     = occ != 2'd0;
    assign head_data = data0;
    assign head_last = last0 && valid;

    assert property (@(posedge clk) disable iff (rst) !(push && !pop && occ == 2'd2));
endmodule

// File: rtl/idma_wdata_burst_ctrl.sv
// idma_wdata_burst_ctrl: pops a command's worth of words from the data FIFO and streams them
// onto the AXI W channel through a 2-entry buffer, tagging the final beat with wlast.
module idma_wdata_burst_ctrl
    import idma_wdata_burst_ctrl_pkg::*;
#(
    parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LEN_W      = DEF_LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         soft_clr,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [LEN_W-1:0]             cmd_len,
    output logic                         fifo_pop,
    input  logic                         fifo_valid,
    input  logic [FIFO_WIDTH-1:0]        fifo_data,
    input  logic                         fifo_empty,
    output logic                         fifo_init,
    output logic                         wvalid,
    input  logic                         wready,
    output logic [DATA_W-1:0]            wdata,
    output logic [FIFO_WIDTH-DATA_W-1:0] wstrb,
    output logic                         wlast,
    output logic                         burst_done
);
    state_e                state, state_nxt;
    logic [LEN_W-1:0]      pop_cnt, send_cnt;
    logic                  pop_done, inflight, inflight_last;
    logic                  w_fire, capture;
    logic [1:0]            occ;
    logic [2:0]            load;
    logic [FIFO_WIDTH-1:0] head;

    assign w_fire = wvalid && wready;
    // words buffered or in flight after this cycle's drain; a new pop must keep it below 2
    assign load = {1'b0, occ} + {2'b0, inflight} - {2'b0, w_fire};
    // data from a pop issued before a flush is dropped, including the cycle right after it
    assign capture = fifo_valid && state == BURST && !soft_clr && !fifo_init;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = soft_clr                 ? IDLE  :
                    (cmd_valid && cmd_ready) ? BURST :
                    (w_fire && wlast)        ? IDLE  : state;
    end

    always_comb begin
        cmd_ready  = state == IDLE && !soft_clr;
        fifo_pop   = state == BURST && !pop_done && !fifo_empty && !soft_clr && load < 3'd2;
        burst_done = w_fire && wlast && !soft_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pop_cnt       <= '0;
            send_cnt      <= '0;
            pop_done      <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fifo_init     <= 1'b0;
        end else begin
            fifo_init     <= soft_clr;
            inflight      <= fifo_pop;
            inflight_last <= fifo_pop && pop_cnt == '0;
            if (soft_clr) begin
                pop_cnt  <= '0;
                send_cnt <= '0;
                pop_done <= 1'b0;
            end else if (cmd_valid && cmd_ready) begin
                pop_cnt  <= cmd_len;
                send_cnt <= cmd_len;
                pop_done <= 1'b0;
            end else begin
                if (fifo_pop && pop_cnt != '0) pop_cnt <= pop_cnt - 1'b1;
                if (fifo_pop && pop_cnt == '0) pop_done <= 1'b1;
                if (w_fire && send_cnt != '0) send_cnt <= send_cnt - 1'b1;
            end
        end
    end

    idma_wdata_skid2 #(.WIDTH(FIFO_WIDTH)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .clr       (soft_clr),
        .push      (capture),
        .push_data (fifo_data),
        .push_last (inflight_last),
        .pop       (w_fire),
        .head_data (head),
        .head_last (wlast),
        .valid     (wvalid),
        .occ       (occ)
    );

    assign wdata = head[DATA_W-1:0];
    assign wstrb = head[FIFO_WIDTH-1:DATA_W];

    assert property (@(posedge clk) disable iff (rst) wvalid |-> (wlast == (send_cnt == '0)));
endmodule

// File: tb/tb_idma_wdata_burst_ctrl.sv
// tb_idma_wdata_burst_ctrl: randomized bench; a queue FIFO feeds the DUT and every W beat is
// checked against the word order of the FIFO with the last tag on beat cmd_len.
module tb_idma_wdata_burst_ctrl;
    localparam int FW = 288;
    localparam int DW = 256;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst, soft_clr, cmd_valid, cmd_ready, fifo_pop, fifo_valid, fifo_empty, fifo_init;
    logic [LW-1:0] cmd_len;
    logic [FW-1:0] fifo_data;
    logic          wvalid, wready, wlast, burst_done;
    logic [DW-1:0] wdata;
    logic [FW-DW-1:0] wstrb;

    idma_wdata_burst_ctrl #(.FIFO_WIDTH(FW), .DATA_W(DW), .LEN_W(LW)) dut (
        .clk        (clk),
        .rst        (rst),
        .soft_clr   (soft_clr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_len    (cmd_len),
        .fifo_pop   (fifo_pop),
        .fifo_valid (fifo_valid),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_init  (fifo_init),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .burst_done (burst_done)
    );

    always #5 clk = ~clk;

    int            n_assert = 0, n_fail = 0, cyc_n = 0;
    logic [FW-1:0] q[$], trickle[$], feed[$];
    logic [FW:0]   beats_q[$], exp_q[$];
    int            cmds[$];
    logic          pend = 1'b0;
    logic [FW-1:0] pend_word;
    int            pops, done_cnt, acc_cyc, first_beat, last_beat;
    int            empty_pop_err, held_err, stall_err, done_err;
    logic          acc, prev_stall;
    logic [FW:0]   prev_w;

    function automatic logic [FW-1:0] rand_word();
        logic [FW-1:0] w;
        for (int i = 0; i < FW / 32; i++) w[i*32 +: 32] = $urandom;
        return w;
    endfunction

    task automatic clear_stats();
        pops = 0; done_cnt = 0; acc_cyc = 0; first_beat = -1; last_beat = -1;
        empty_pop_err = 0; held_err = 0; stall_err = 0; done_err = 0;
        prev_stall = 1'b0; acc = 1'b0;
        beats_q.delete(); exp_q.delete(); cmds.delete();
    endtask

    task automatic load(input int n, input bit slow);
        logic [FW-1:0] w;
        for (int k = 0; k < n; k++) begin
            w = rand_word();
            feed.push_back(w);
            if (slow) trickle.push_back(w);
            else q.push_back(w);
        end
    endtask

    // a burst of len+1 beats takes the next words in FIFO order; only the final one is last
    task automatic expect_burst(input int len);
        for (int k = 0; k <= len; k++) exp_q.push_back({k == len, feed.pop_front()});
    endtask

    // one clock: drive at the falling edge, observe what the next rising edge will do
    task automatic cyc(input logic wr, input logic cv, input logic [LW-1:0] cl, input logic sc);
        @(negedge clk);
        cyc_n++;
        wready = wr; cmd_valid = cv; cmd_len = cl; soft_clr = sc;
        fifo_valid = pend;
        fifo_data = pend ? pend_word : '0;
        pend = 1'b0;
        if (trickle.size() > 0 && cyc_n % 3 == 0) q.push_back(trickle.pop_front());
        fifo_empty = q.size() == 0;
        #1;
        if (prev_stall && (!wvalid || {wlast, wstrb, wdata} != prev_w)) stall_err++;
        prev_stall = wvalid && !wready && !sc;
        prev_w = {wlast, wstrb, wdata};
        acc = cv && cmd_ready;
        if (acc) acc_cyc = cyc_n;
        if (fifo_pop && fifo_empty) empty_pop_err++;
        else if (fifo_pop) begin
            pend = 1'b1;
            pend_word = q.pop_front();
            pops++;
        end
        if (wvalid && wready) begin
            beats_q.push_back({wlast, wstrb, wdata});
            if (first_beat < 0) first_beat = cyc_n;
            last_beat = cyc_n;
        end
        if (burst_done) begin
            done_cnt++;
            if (!(wvalid && wready && wlast)) done_err++;
        end
        if (pops - beats_q.size() > 2) held_err++;
        if (fifo_init) q.delete();
    endtask

    // issues every length in cmds (holding cmd_valid) and runs until all bursts complete
    task automatic run_cmds(input int mode, output bit ok);
        int   i, target, budget;
        logic wr;
        logic [LW-1:0] l;
        i = 0; budget = 0;
        target = done_cnt + cmds.size();
        while (done_cnt < target && budget < 500) begin
            wr = mode == 0 ? 1'b1 : mode == 1 ? 1'(cyc_n % 2) : 1'($urandom_range(0, 1));
            l = '0;
            if (i < cmds.size()) l = LW'(cmds[i]);
            cyc(wr, i < cmds.size(), l, 1'b0);
            if (acc) i++;
            budget++;
        end
        ok = done_cnt == target;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_assert++;
        if ({cmd_ready, fifo_pop, fifo_init, wvalid, wlast, burst_done} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 100000 (cmd_ready,pop,init,wvalid,wlast,done)",
                     {cmd_ready, fifo_pop, fifo_init, wvalid, wlast, burst_done});
        end
        n_assert++;
        if (wdata !== '0) begin n_fail++; $display("FAIL reset_wdata: got %h want 0", wdata); end
        n_assert++;
        if (wstrb !== '0) begin n_fail++; $display("FAIL reset_wstrb: got %h want 0", wstrb); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic();
        bit ok;
        clear_stats();
        load(4, 0);
        expect_burst(3);
        cmds.push_back(3);
        run_cmds(0, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL basic_done_timeout: got %0d done want 1", done_cnt); end
        n_assert++;
        if (beats_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL basic_beat_count: got %0d want %0d", beats_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < beats_q.size()) begin
            n_assert++;
            if (beats_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL basic_beat%0d: got %h want %h", i, beats_q[i], exp_q[i]);
            end
        end
        n_assert++;
        if (pops != 4) begin n_fail++; $display("FAIL basic_pops: got %0d want 4", pops); end
        n_assert++;
        if (last_beat - first_beat != 3) begin
            n_fail++; $display("FAIL basic_consecutive: got span %0d want 3", last_beat - first_beat);
        end
        n_assert++;
        if (first_beat - acc_cyc < 2) begin
            n_fail++; $display("FAIL basic_first_latency: got %0d want >=2", first_beat - acc_cyc);
        end
        n_assert++;
        if (done_err != 0) begin n_fail++; $display("FAIL basic_done_pulse: got %0d stray want 0", done_err); end
    endtask

    task automatic test_single();
        bit ok;
        clear_stats();
        load(3, 0);
        expect_burst(0);
        cmds.push_back(0);
        run_cmds(0, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL single_done_timeout: got %0d done want 1", done_cnt); end
        n_assert++;
        if (beats_q.size() != 1) begin n_fail++; $display("FAIL single_beat_count: got %0d want 1", beats_q.size()); end
        n_assert++;
        if (beats_q.size() > 0 && beats_q[0] !== exp_q[0]) begin
            n_fail++; $display("FAIL single_beat: got %h want %h", beats_q[0], exp_q[0]);
        end
        n_assert++;
        if (pops != 1) begin n_fail++; $display("FAIL single_pops: got %0d want 1", pops); end
        cyc(1'b1, 1'b0, '0, 1'b0);
        n_assert++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL single_cmd_ready: got %b want 1", cmd_ready); end
        n_assert++;
        if (q.size() != 2) begin n_fail++; $display("FAIL single_fifo_left: got %0d want 2", q.size()); end
        q.delete(); feed.delete();
    endtask

    task automatic test_stall();
        bit ok;
        clear_stats();
        load(8, 0);
        expect_burst(7);
        cmds.push_back(7);
        run_cmds(1, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL stall_done_timeout: got %0d done want 1", done_cnt); end
        n_assert++;
        if (beats_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stall_beat_count: got %0d want %0d", beats_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < beats_q.size()) begin
            n_assert++;
            if (beats_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL stall_beat%0d: got %h want %h", i, beats_q[i], exp_q[i]);
            end
        end
        n_assert++;
        if (stall_err != 0) begin n_fail++; $display("FAIL stall_stable: got %0d changes want 0", stall_err); end
        n_assert++;
        if (held_err != 0) begin n_fail++; $display("FAIL stall_held: got %0d overflows want 0", held_err); end
    endtask

    task automatic test_trickle();
        bit ok;
        clear_stats();
        load(4, 1);
        expect_burst(3);
        cmds.push_back(3);
        run_cmds(0, ok);
        n_assert++;
        if (!ok) begin n_fail++; $display("FAIL trickle_done_timeout: got %0d done want 1", done_cnt); end
        n_assert++;
        if (empty_pop_err != 0) begin
            n_fail++; $display("FAIL trickle_pop_empty: got %0d pops while empty want 0", empty_pop_err);
        end
        n_assert++;
        if (beats_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL trickle_beat_count: got %0d want %0d", beats_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < beats_q.size()) begin
            n_assert++;
            if (beats_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL trickle_beat%0d: got %h want %h", i, beats_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_stats();
        load(5, 0);
        expect_burst(1);
        expect_burst(2);
        cmds.push_back(1);
        cmds.push_back(2);
        run_cmds(0, ok);
        n_assert++;
        if (!ok || done_cnt != 2) begin n_fail++; $display("FAIL b2b_done: got %0d want 2", done_cnt); end
        n_assert++;
        if (beats_q.size() != 5) begin n_fail++; $display("FAIL b2b_beat_count: got %0d want 5", beats_q.size()); end
        foreach (exp_q[i]) if (i < beats_q.size()) begin
            n_assert++;
            if (beats_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL b2b_beat%0d: got %h want %h", i, beats_q[i], exp_q[i]);
            end
        end
        n_assert++;
        if (done_err != 0) begin n_fail++; $display("FAIL b2b_done_pulse: got %0d stray want 0", done_err); end
    endtask

    task automatic test_soft_clr();
        int b;
        clear_stats();
        load(16, 0);
        expect_burst(15);
        while (exp_q.size() > 5) void'(exp_q.pop_back());
        b = 0;
        do begin cyc(1'b1, 1'b1, 8'd15, 1'b0); b++; end while (!acc && b < 20);
        b = 0;
        while (beats_q.size() < 5 && b < 100) begin cyc(1'b1, 1'b0, '0, 1'b0); b++; end
        n_assert++;
        if (beats_q.size() != 5) begin n_fail++; $display("FAIL clr_reach_beat5: got %0d want 5", beats_q.size()); end
        cyc(1'b0, 1'b0, '0, 1'b1);
        pend = 1'b1;
        pend_word = rand_word();
        cyc(1'b1, 1'b0, '0, 1'b0);
        n_assert++;
        if ({fifo_init, wvalid, cmd_ready, burst_done} !== 4'b1010) begin
            n_fail++; $display("FAIL clr_next_cycle: got %b want 1010 (init,wvalid,cmd_ready,done)",
                               {fifo_init, wvalid, cmd_ready, burst_done});
        end
        cyc(1'b1, 1'b0, '0, 1'b0);
        n_assert++;
        if ({fifo_init, wvalid} !== 2'b00) begin
            n_fail++; $display("FAIL clr_discard: got %b want 00 (init,wvalid)", {fifo_init, wvalid});
        end
        n_assert++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL clr_no_done: got %0d want 0", done_cnt); end
        foreach (exp_q[i]) if (i < beats_q.size()) begin
            n_assert++;
            if (beats_q[i] !== exp_q[i]) begin
                n_fail++; $display("FAIL clr_beat%0d: got %h want %h", i, beats_q[i], exp_q[i]);
            end
        end
        feed.delete(); q.delete();
    endtask

    task automatic test_reset_mid_burst();
        int b, n;
        clear_stats();
        load(8, 0);
        b = 0;
        do begin cyc(1'b1, 1'b1, 8'd7, 1'b0); b++; end while (!acc && b < 20);
        b = 0;
        while (beats_q.size() < 2 && b < 100) begin cyc(1'b1, 1'b0, '0, 1'b0); b++; end
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_assert++;
        if ({wvalid, fifo_pop, cmd_ready} !== 3'b001) begin
            n_fail++; $display("FAIL rstmid_outputs: got %b want 001 (wvalid,pop,cmd_ready)", {wvalid, fifo_pop, cmd_ready});
        end
        @(negedge clk);
        rst = 1'b0;
        n = beats_q.size();
        repeat (6) cyc(1'b1, 1'b0, '0, 1'b0);
        n_assert++;
        if (beats_q.size() != n || done_cnt != 0) begin
            n_fail++; $display("FAIL rstmid_no_beats: got %0d beats %0d done want %0d beats 0 done",
                               beats_q.size(), done_cnt, n);
        end
        q.delete(); feed.delete(); pend = 1'b0;
    endtask

    task automatic test_random();
        bit ok;
        int l, total;
        for (int r = 0; r < 4; r++) begin
            clear_stats();
            total = 0;
            for (int c = 0; c < 3; c++) begin
                l = $urandom_range(0, 7);
                cmds.push_back(l);
                total += l + 1;
            end
            load(total, 0);
            foreach (cmds[c]) expect_burst(cmds[c]);
            run_cmds(2, ok);
            n_assert++;
            if (!ok) begin n_fail++; $display("FAIL rand%0d_done: got %0d want 3", r, done_cnt); end
            n_assert++;
            if (beats_q.size() != exp_q.size()) begin
                n_fail++; $display("FAIL rand%0d_beat_count: got %0d want %0d", r, beats_q.size(), exp_q.size());
            end
            foreach (exp_q[i]) if (i < beats_q.size()) begin
                n_assert++;
                if (beats_q[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rand%0d_beat%0d: got %h want %h", r, i, beats_q[i], exp_q[i]);
                end
            end
            n_assert++;
            if (stall_err + held_err + done_err != 0) begin
                n_fail++; $display("FAIL rand%0d_protocol: got stall %0d held %0d done %0d want 0 0 0",
                                   r, stall_err, held_err, done_err);
            end
        end
    endtask

    initial begin
        rst = 1'b1; soft_clr = 1'b0; cmd_valid = 1'b0; cmd_len = '0; wready = 1'b0;
        fifo_valid = 1'b0; fifo_data = '0; fifo_empty = 1'b1;
        test_reset();
        test_basic();
        test_single();
        test_stall();
        test_trickle();
        test_back_to_back();
        test_soft_clr();
        test_reset_mid_burst();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
